// File: rtl/lcd_window_blit.sv
// Programs an LCD address window (CASET/PASET/RAMWR) and then streams length*width pixels as bytes.
// Latency: first command byte is requested the cycle after start; each pixel fetch takes RD_LAT+2 cycles.
// Backpressure: every byte is held on lcd_wr_en until lcd_wr_done, followed by at least one idle cycle.
module lcd_window_blit #(
  parameter int COORD_W   = 16,
  parameter int PIX_BYTES = 3,
  parameter int ADDR_W    = 18,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic [COORD_W-1:0]     length,
  input  logic [COORD_W-1:0]     width,
  input  logic                   mode,
  input  logic [8*PIX_BYTES-1:0] fill_color,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [8*PIX_BYTES-1:0] mem_rdata,
  output logic [7:0]             lcd_data,
  output logic                   lcd_dc,
  output logic                   lcd_wr_en,
  input  logic                   lcd_wr_done,
  output logic                   busy,
  output logic                   done
);

  localparam int PW  = 8 * PIX_BYTES;
  localparam int CW2 = 2 * COORD_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FETCH,
    S_PIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Request latched at start so later input changes cannot disturb a running blit.
  logic [COORD_W-1:0] x_r, y_r, len_r, wid_r;
  logic               mode_r;
  logic [ADDR_W-1:0]  base_r;
  logic [PW-1:0]      pix_r;

  logic [3:0]         cmd_idx;
  logic [1:0]         byte_idx;
  logic [CW2-1:0]     pix_cnt;
  logic [2:0]         lat_cnt;

  logic [COORD_W-1:0] xe, ye;
  logic [CW2-1:0]     npix;
  logic               zero_req;
  logic               byte_done;
  logic               last_byte;
  logic               last_pix;
  logic               fetch_end;
  logic [7:0]         cmd_byte;
  logic               cmd_dc;
  logic [7:0]         pix_byte;

  assign xe        = x_r + len_r - COORD_W'(1);
  assign ye        = y_r + wid_r - COORD_W'(1);
  assign npix      = CW2'(len_r) * CW2'(wid_r);
  assign zero_req  = (length == '0) || (width == '0);
  assign byte_done = lcd_wr_en && lcd_wr_done;
  assign last_byte = (byte_idx == 2'(PIX_BYTES - 1));
  assign last_pix  = (pix_cnt == npix - CW2'(1));
  assign fetch_end = (lat_cnt == 3'(RD_LAT + 1));

  assign busy = (state == S_CMD) || (state == S_FETCH) || (state == S_PIX);
  assign done = (state == S_DONE);

  // Window-programming byte sequence selected by the command index.
  always_comb begin
    cmd_byte = 8'h00;
    cmd_dc   = 1'b1;
    case (cmd_idx)
      4'd0:    begin cmd_byte = 8'h2A; cmd_dc = 1'b0; end
      4'd1:    cmd_byte = x_r[15:8];
      4'd2:    cmd_byte = x_r[7:0];
      4'd3:    cmd_byte = xe[15:8];
      4'd4:    cmd_byte = xe[7:0];
      4'd5:    begin cmd_byte = 8'h2B; cmd_dc = 1'b0; end
      4'd6:    cmd_byte = y_r[15:8];
      4'd7:    cmd_byte = y_r[7:0];
      4'd8:    cmd_byte = ye[15:8];
      4'd9:    cmd_byte = ye[7:0];
      4'd10:   begin cmd_byte = 8'h2C; cmd_dc = 1'b0; end
      default: cmd_byte = 8'h00;
    endcase
  end

  // Pixel byte selection, most significant byte first.
  always_comb begin
    pix_byte = 8'h00;
    for (int i = 0; i < PIX_BYTES; i++) begin
      if (byte_idx == i[1:0]) pix_byte = pix_r[8*(PIX_BYTES-1-i) +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a zero-area window goes straight to DONE without touching the bus.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = zero_req ? S_DONE : S_CMD;
      S_CMD:   if (byte_done && cmd_idx == 4'd10) state_nxt = mode_r ? S_PIX : S_FETCH;
      S_FETCH: if (fetch_end) state_nxt = S_PIX;
      S_PIX: begin
        if (byte_done && last_byte) begin
          if (last_pix)     state_nxt = S_DONE;
          else if (!mode_r) state_nxt = S_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request latching, byte handshake, counters and pixel fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r       <= '0;
      y_r       <= '0;
      len_r     <= '0;
      wid_r     <= '0;
      mode_r    <= 1'b0;
      base_r    <= '0;
      pix_r     <= '0;
      cmd_idx   <= '0;
      byte_idx  <= '0;
      pix_cnt   <= '0;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      lcd_data  <= 8'h00;
      lcd_dc    <= 1'b0;
      lcd_wr_en <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r      <= x;
            y_r      <= y;
            len_r    <= length;
            wid_r    <= width;
            mode_r   <= mode;
            base_r   <= base_addr;
            pix_r    <= fill_color;
            cmd_idx  <= '0;
            byte_idx <= '0;
            pix_cnt  <= '0;
            lat_cnt  <= '0;
            if (!zero_req) begin
              lcd_wr_en <= 1'b1;
              lcd_data  <= 8'h2A;
              lcd_dc    <= 1'b0;
            end
          end
        end
        S_CMD: begin
          if (byte_done) begin
            lcd_wr_en <= 1'b0;
            if (cmd_idx != 4'd10) cmd_idx <= cmd_idx + 4'd1;
          end else if (!lcd_wr_en) begin
            lcd_wr_en <= 1'b1;
            lcd_data  <= cmd_byte;
            lcd_dc    <= cmd_dc;
          end
        end
        S_FETCH: begin
          // Address is presented on the first cycle; data is sampled RD_LAT+1 cycles later.
          if (lat_cnt == 3'd0) mem_addr <= base_r + pix_cnt[ADDR_W-1:0];
          if (fetch_end) begin
            pix_r   <= mem_rdata;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_PIX: begin
          if (byte_done) begin
            lcd_wr_en <= 1'b0;
            if (last_byte) begin
              byte_idx <= '0;
              pix_cnt  <= pix_cnt + CW2'(1);
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end else if (!lcd_wr_en) begin
            lcd_wr_en <= 1'b1;
            lcd_data  <= pix_byte;
            lcd_dc    <= 1'b1;
          end
        end
        S_DONE: lcd_wr_en <= 1'b0;
        default: lcd_wr_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_window_blit.sv
// Testbench for lcd_window_blit: two instances (3-byte/RD_LAT=1 and 2-byte/RD_LAT=3),
// a randomized byte-writer responder and a byte-stream reference built from the window rules.
module tb_lcd_window_blit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sel, wr_done;
  logic [15:0] x, y, length, width;
  logic        mode;
  logic [23:0] fill;
  logic [17:0] base;

  logic [17:0] addr_a, addr_b, o_addr;
  logic [7:0]  data_a, data_b, o_data;
  logic        dc_a, dc_b, en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic        o_dc, o_en, o_busy, o_done;
  logic [23:0] rdata_a, mfb;
  logic [15:0] rdata_b, pb0, pb1, pb2;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  always #5 clk = ~clk;

  lcd_window_blit #(.COORD_W(16), .PIX_BYTES(3), .ADDR_W(18), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .x(x), .y(y), .length(length),
    .width(width), .mode(mode), .fill_color(fill), .base_addr(base), .mem_addr(addr_a),
    .mem_rdata(rdata_a), .lcd_data(data_a), .lcd_dc(dc_a), .lcd_wr_en(en_a),
    .lcd_wr_done(wr_done & ~sel), .busy(busy_a), .done(done_a));

  lcd_window_blit #(.COORD_W(16), .PIX_BYTES(2), .ADDR_W(18), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .x(x), .y(y), .length(length),
    .width(width), .mode(mode), .fill_color(fill[15:0]), .base_addr(base), .mem_addr(addr_b),
    .mem_rdata(rdata_b), .lcd_data(data_b), .lcd_dc(dc_b), .lcd_wr_en(en_b),
    .lcd_wr_done(wr_done & sel), .busy(busy_b), .done(done_b));

  assign o_addr = sel ? addr_b : addr_a;
  assign o_data = sel ? data_b : data_a;
  assign o_dc   = sel ? dc_b   : dc_a;
  assign o_en   = sel ? en_b   : en_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;

  function automatic logic [23:0] memf(input logic [17:0] a);
    memf = {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5, {6'b0, a[17:16]} ^ (a[7:0] + 8'h11)};
  endfunction

  // Pixel memories: data appears RD_LAT clocks after the address changes.
  assign mfb = memf(addr_b);
  always @(posedge clk) rdata_a <= memf(addr_a);
  always @(posedge clk) begin
    pb0 <= mfb[15:0];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rdata_b = pb2;

  // Runs one window request end to end with a randomized writer and checks the byte stream.
  task automatic run_window(input bit s, input logic [15:0] xi, input logic [15:0] yi,
                            input logic [15:0] li, input logic [15:0] wi, input logic mi,
                            input logic [23:0] fi, input logic [17:0] bi,
                            input int dlo, input int dhi, input bit disturb, input bit sod);
    logic [15:0] xe, ye;
    logic [23:0] pix;
    logic [17:0] a, addr0;
    logic [8:0]  cur;
    int n, nb, dly, wait_c, proto_err, busy_err, addr_err, tail_err, done_cnt;
    bit in_req, acked, done_seen, zero;
    exp_q.delete();
    got_q.delete();
    nb   = s ? 2 : 3;
    zero = (li == 16'd0) || (wi == 16'd0);
    if (!zero) begin
      xe = xi + li - 16'd1;
      ye = yi + wi - 16'd1;
      exp_q.push_back({1'b0, 8'h2A});
      exp_q.push_back({1'b1, xi[15:8]}); exp_q.push_back({1'b1, xi[7:0]});
      exp_q.push_back({1'b1, xe[15:8]}); exp_q.push_back({1'b1, xe[7:0]});
      exp_q.push_back({1'b0, 8'h2B});
      exp_q.push_back({1'b1, yi[15:8]}); exp_q.push_back({1'b1, yi[7:0]});
      exp_q.push_back({1'b1, ye[15:8]}); exp_q.push_back({1'b1, ye[7:0]});
      exp_q.push_back({1'b0, 8'h2C});
      n = int'(li) * int'(wi);
      for (int p = 0; p < n; p++) begin
        a   = bi + 18'(p);
        pix = mi ? fi : memf(a);
        for (int b = nb - 1; b >= 0; b--) exp_q.push_back({1'b1, pix[8*b +: 8]});
      end
    end
    @(negedge clk);
    sel = s; wr_done = 1'b0;
    @(negedge clk);
    addr0 = o_addr;
    x = xi; y = yi; length = li; width = wi; mode = mi; fill = fi; base = bi;
    start = 1'b1;
    proto_err = 0; busy_err = 0; addr_err = 0; tail_err = 0; done_cnt = 0;
    in_req = 0; acked = 0; done_seen = 0; wait_c = 0; dly = 0; cur = '0;
    for (int cyc = 0; cyc < 6000 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      wr_done = 1'b0;
      if (cyc == 0) begin
        checks++;
        if (zero && !(o_done === 1'b1 && o_en === 1'b0 && o_busy === 1'b0))
          begin failures++; $display("FAIL zero_first_cycle: done=%b en=%b busy=%b, want done=1 en=0 busy=0", o_done, o_en, o_busy); end
        if (!zero && !(o_en === 1'b1 && o_data === 8'h2A && o_dc === 1'b0 && o_busy === 1'b1 && o_done === 1'b0))
          begin failures++; $display("FAIL first_byte: en=%b data=%h dc=%b busy=%b, want en=1 data=2a dc=0 busy=1", o_en, o_data, o_dc, o_busy); end
      end
      if (disturb && cyc == 4) begin x = ~xi; start = 1'b1; end
      if (mi && o_addr !== addr0) addr_err++;
      if (o_done === 1'b1) begin
        done_cnt++; done_seen = 1;
        if (o_busy !== 1'b0 || o_en !== 1'b0) busy_err++;
        if (sod) start = 1'b1;
      end else if (o_busy !== (zero ? 1'b0 : 1'b1)) busy_err++;
      if (acked) begin
        if (o_en !== 1'b0) proto_err++;
        acked = 0;
      end else if (in_req) begin
        if (o_en !== 1'b1) begin proto_err++; in_req = 0; end
        else if ({o_dc, o_data} !== cur) proto_err++;
      end else if (o_en === 1'b1) begin
        cur = {o_dc, o_data};
        got_q.push_back(cur);
        in_req = 1; wait_c = 0;
        dly = $urandom_range(dhi, dlo);
      end
      if (in_req) begin
        if (wait_c == dly) begin wr_done = 1'b1; in_req = 0; acked = 1; end
        else wait_c++;
      end else if (!acked && o_en === 1'b0 && ($urandom % 8) == 0) begin
        wr_done = 1'b1;  // stray pulse while idle must be ignored
      end
    end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      start = 1'b0; wr_done = 1'b0;
      if (o_en !== 1'b0 || o_busy !== 1'b0) tail_err++;
      if (o_done === 1'b1) done_cnt++;
    end
    checks++;
    if (!done_seen) begin failures++; $display("FAIL timeout: no done within budget, bytes=%0d want %0d", got_q.size(), exp_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL byte_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL byte[%0d]: got dc/data %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (proto_err != 0) begin failures++; $display("FAIL handshake: %0d violations, want 0", proto_err); end
    checks++;
    if (busy_err != 0) begin failures++; $display("FAIL busy_window: %0d bad cycles, want 0", busy_err); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if (tail_err != 0) begin failures++; $display("FAIL idle_after_done: %0d active cycles, want 0", tail_err); end
    if (mi) begin
      checks++;
      if (addr_err != 0) begin failures++; $display("FAIL fill_mem_addr: moved on %0d cycles, want 0", addr_err); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({addr_a, data_a, dc_a, en_a, busy_a, done_a} !== '0)
      begin failures++; $display("FAIL reset_a: outputs %h want 0", {addr_a, data_a, dc_a, en_a, busy_a, done_a}); end
    checks++;
    if ({addr_b, data_b, dc_b, en_b, busy_b, done_b} !== '0)
      begin failures++; $display("FAIL reset_b: outputs %h want 0", {addr_b, data_b, dc_b, en_b, busy_b, done_b}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_image_directed();
    run_window(1'b0, 16'd10, 16'd20, 16'd2, 16'd2, 1'b0, 24'h0, 18'h100, 3, 3, 1'b0, 1'b0);
    checks++;
    if (got_q.size() < 5 || got_q[3] !== {1'b1, 8'h00} || got_q[4] !== {1'b1, 8'h0B})
      begin failures++; $display("FAIL caset_end: size=%0d, want xe bytes 00 0b", got_q.size()); end
  endtask

  task automatic test_fill_565();
    run_window(1'b1, 16'd7, 16'd9, 16'd3, 16'd1, 1'b1, 24'h00F800, 18'h2A5, 0, 3, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != 17 || got_q[11] !== {1'b1, 8'hF8} || got_q[12] !== {1'b1, 8'h00})
      begin failures++; $display("FAIL fill565_first_pixel: size=%0d, want 17 bytes starting f8 00", got_q.size()); end
  endtask

  task automatic test_zero();
    run_window(1'b0, 16'd5, 16'd5, 16'd0, 16'd5, 1'b0, 24'h0, 18'h0, 0, 2, 1'b0, 1'b1);
    run_window(1'b1, 16'd5, 16'd5, 16'd4, 16'd0, 1'b1, 24'h1234, 18'h0, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_mid_change();
    run_window(1'b0, 16'h0123, 16'h0045, 16'd2, 16'd1, 1'b0, 24'h0, 18'h3000, 1, 4, 1'b1, 1'b0);
    checks++;
    if (got_q.size() < 3 || got_q[1] !== {1'b1, 8'h01} || got_q[2] !== {1'b1, 8'h23})
      begin failures++; $display("FAIL latched_x: size=%0d, want x bytes 01 23", got_q.size()); end
  endtask

  task automatic test_delay_sweep();
    for (int d = 0; d < 8; d++)
      run_window(d[0], 16'($urandom_range(300)), 16'($urandom_range(300)), 16'd2, 16'd1,
                 1'($urandom_range(1)), 24'($urandom), 18'($urandom), d, d, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_window(1'b0, 16'hFFFE, 16'hFFFF, 16'd3, 16'd1, 1'b1, 24'hABCDEF, 18'h0, 0, 1, 1'b0, 1'b0);
    checks++;
    if (got_q.size() < 10 || got_q[3] !== {1'b1, 8'h00} || got_q[4] !== {1'b1, 8'h00} || got_q[9] !== {1'b1, 8'hFF})
      begin failures++; $display("FAIL wrap_end: size=%0d, want xe 00 00 and ye low ff", got_q.size()); end
  endtask

  task automatic test_reset_mid_pix();
    int cnt;
    @(negedge clk);
    sel = 1'b0; wr_done = 1'b0;
    @(negedge clk);
    x = 16'd1; y = 16'd2; length = 16'd3; width = 16'd2; mode = 1'b0; base = 18'h100;
    start = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      wr_done = 1'b0;
      if (en_a === 1'b1) begin
        if (cnt == 14) break;
        wr_done = 1'b1;
        cnt++;
      end
    end
    checks++;
    if (cnt != 14 || en_a !== 1'b1) begin failures++; $display("FAIL reach_pix: bytes=%0d en=%b, want 14 and 1", cnt, en_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (en_a !== 1'b0 || busy_a !== 1'b0 || addr_a !== '0 || data_a !== 8'h00)
      begin failures++; $display("FAIL async_reset: en=%b busy=%b addr=%h data=%h, want all 0", en_a, busy_a, addr_a, data_a); end
    @(negedge clk);
    rst_n = 1'b1;
    run_window(1'b0, 16'd1, 16'd2, 16'd3, 16'd2, 1'b0, 24'h0, 18'h100, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      run_window(1'($urandom_range(1)), 16'($urandom), 16'($urandom),
                 16'($urandom_range(4, 1)), 16'($urandom_range(3, 1)), 1'($urandom_range(1)),
                 24'($urandom), (k % 4 == 0) ? 18'h3FFFE : 18'($urandom),
                 0, 4, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    start = 1'b0; sel = 1'b0; wr_done = 1'b0;
    x = '0; y = '0; length = '0; width = '0; mode = 1'b0; fill = '0; base = '0;
    test_reset();
    test_image_directed();
    test_fill_565();
    test_zero();
    test_mid_change();
    test_delay_sweep();
    test_wrap();
    test_reset_mid_pix();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_window_blit.md
Name: lcd_window_blit

Overview:
- Parametrised successor to the single-format picture writer. Programs an LCD address window (CASET 0x2A / PASET 0x2B / RAMWR 0x2C), then streams length×width pixels as bytes to the byte-level SPI/8080 writer.
- Supports 2- or 3-byte pixel formats and a configurable pixel-memory read latency.
- Two modes: image (pixels read from memory at base_addr) and solid fill (constant colour, no memory reads).
- Sits between the top-level display controller and the byte writer.

Parameters:
- COORD_W, 16, width of x/y/length/width and of the window coordinate bytes sent (must be 16).
- PIX_BYTES, 3, bytes per pixel on the wire; 3 = RGB666/888, 2 = RGB565; other values illegal.
- ADDR_W, 18, pixel memory address width.
- RD_LAT, 1, cycles from mem_addr change to valid mem_rdata (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- x  in  COORD_W  window start column
- y  in  COORD_W  window start row
- length  in  COORD_W  window columns
- width  in  COORD_W  window rows
- mode  in  1  0 = image from memory, 1 = solid fill
- fill_color  in  8*PIX_BYTES  colour for mode 1
- base_addr  in  ADDR_W  memory address of first pixel
- mem_addr  out  ADDR_W  pixel memory read address
- mem_rdata  in  8*PIX_BYTES  pixel memory data
- lcd_data  out  8  byte to writer
- lcd_dc  out  1  0 = command, 1 = data
- lcd_wr_en  out  1  byte request level
- lcd_wr_done  in  1  one-cycle byte-accepted pulse from writer
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, any state): state IDLE. All outputs 0: mem_addr, lcd_data, lcd_dc, lcd_wr_en, busy, done. Any in-flight byte is abandoned.
- Start acceptance: start && IDLE latches x, y, length, width, mode, fill_color, base_addr. Input changes afterwards have no effect. start while busy is ignored.
- Window ends:
  - xe = x+length-1 and ye = y+width-1, truncated to COORD_W (wrap permitted, not flagged).
  - Pixel count N = length*width, computed at 2*COORD_W bits.
- Zero-size window: length==0 or width==0 → no bytes sent. busy stays 0; done=1 on the cycle after start.
- Byte handshake:
  - lcd_data and lcd_dc are stable while lcd_wr_en=1.
  - lcd_wr_en stays high until lcd_wr_done is sampled high; lcd_wr_done while lcd_wr_en=0 is ignored.
  - After each lcd_wr_done, lcd_wr_en is low for ≥1 cycle before the next byte.
- States:
  - IDLE → CMD on accepted non-zero start.
  - CMD: 11 bytes in order: 2A, x[15:8], x[7:0], xe[15:8], xe[7:0], 2B, y[15:8], y[7:0], ye[15:8], ye[7:0], 2C. lcd_dc=0 for 2A/2B/2C, 1 otherwise.
  - First byte: lcd_wr_en=1 with 0x2A on the cycle after start.
  - After the 11th byte's lcd_wr_done: → FETCH (mode 0) or PIX (mode 1).
  - FETCH: mem_addr = base_addr + pixel index (row-major, mod 2^ADDR_W). Wait RD_LAT cycles, capture mem_rdata into the pixel register, → PIX.
  - PIX: send PIX_BYTES bytes, MSB first, lcd_dc=1.
    - Mode 1 uses fill_color and never changes mem_addr.
    - After the last byte of pixel N-1 → DONE.
    - Otherwise → FETCH (mode 0) or stay in PIX (mode 1).
  - DONE: done=1 and busy=0 for one cycle, lcd_wr_en=0 → IDLE.
- Counters:
  - Byte index in pixel: 0..PIX_BYTES-1.
  - Pixel counter: 2*COORD_W bits, 0..N-1.
  - Command index: 0..10.
- mem_addr holds its last value outside FETCH; it is 0 only after reset.
- start arriving on the DONE cycle is ignored; start is honoured from IDLE only.

Test Plan:
- Image mode, PIX_BYTES=3, RD_LAT=1, x=10 y=20 length=2 width=2 base_addr=0x100, mem_rdata=addr-derived, writer returns wr_done 3 cycles after wr_en.
  - Required bytes: 2A 00 0A 00 0B 2B 00 14 00 15 2C, then 12 data bytes from addresses 0x100..0x103 in order, R/G/B MSB first.
  - dc = 0 exactly on 2A/2B/2C; one done pulse; busy low afterwards.
- Solid fill, PIX_BYTES=2, fill_color=0xF800, length=3 width=1.
  - Required bytes: 2A..2C, then F8 00 F8 00 F8 00.
  - mem_addr never changes from its pre-start value.
- length=0 width=5 with start → lcd_wr_en never asserts, busy stays 0, done pulses on the cycle after start.
- Mid-operation input changes: start pulsed and x changed during CMD → no restart, byte stream uses the latched x.
- Sweep wr_done delay 0–7 → lcd_wr_en never drops before done and has ≥1 idle cycle between bytes.
- Boundary and reset:
  - x=0xFFFE length=3 → xe bytes 00 00 (wrap).
  - rst_n low mid-PIX → lcd_wr_en and busy fall asynchronously, and the next start replays the full sequence from 2A.
